// File: rtl/spi_cmd_pkg.sv
// Shared constants, FSM state encoding and checksum helper for the SPI command sequencer.
// The SPI_CMD_CHK_EN build option is resolved in spi_cmd_ctrl; this package is identical in both builds.
package spi_cmd_pkg;

    localparam logic [7:0] OP_WR_DEF  = 8'h02;
    localparam logic [7:0] OP_NOP_DEF = 8'h00;
    localparam int         CHK_W      = 8;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_OPC   = 3'd1;
    localparam state_t S_ADDR  = 3'd2;
    localparam state_t S_DATA  = 3'd3;
    localparam state_t S_SKIP  = 3'd4;
    localparam state_t S_CHK   = 3'd5;
    localparam state_t S_DRAIN = 3'd6;
    localparam state_t S_DONE  = 3'd7;

    function automatic logic [CHK_W-1:0] chk_step(input logic [CHK_W-1:0] acc,
                                                  input logic [7:0]       b);
        return acc ^ CHK_W'(b);
    endfunction

endpackage

// File: rtl/spi_cmd_buf.sv
// Synchronous DEPTH x W FIFO holding checksummed-frame data until the checksum is verified.
// Push is ignored when full, pop when empty; clear empties it in one cycle.
module spi_cmd_buf #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clear,
    input  logic [W-1:0]               i_data,
    output logic [W-1:0]               o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push_ok = i_push & (r_count != CW'(DEPTH));
    assign w_pop_ok  = i_pop & (r_count != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop_ok)  r_rd_ptr <= ptr_next(r_rd_ptr);
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Parses SPI frames [opcode][addr][data...] into register writes on a valid/ready port.
// Define SPI_CMD_CHK_EN to buffer data and only write after a trailing XOR checksum matches.
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int         AW     = 8,
    parameter logic [7:0] OP_WR  = OP_WR_DEF,
    parameter logic [7:0] OP_NOP = OP_NOP_DEF
`ifdef SPI_CMD_CHK_EN
    , parameter int       BUF_DEPTH = 16
`endif
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          spi_ss,
    input  logic          byte_en,
    input  logic [7:0]    byte_in,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          frame_done,
    input  logic          err_clr,
    output logic          err_op,
    output logic          err_ovf,
    output logic          err_chk
);
    // state | meaning
    // IDLE  | waiting for spi_ss fall      OPC   | expecting opcode byte
    // ADDR  | expecting start address      DATA  | data bytes (write or buffer)
    // SKIP  | NOP/unknown, bytes ignored   CHK   | verify checksum (CHK_EN only)
    // DRAIN | replay buffered writes       DONE  | wait for pending write, pulse frame_done

`ifdef SPI_CMD_CHK_EN
    localparam state_t S_DATA_END = S_CHK;
`else
    localparam state_t S_DATA_END = S_DONE;
`endif

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_ss_q;
    logic [AW-1:0] r_addr;
    logic          r_err_op;
    logic          r_err_ovf;
    logic          w_fall;
    logic          w_hs;
    logic          w_data_byte;
    logic          w_op_bad;
    logic          w_ovf;
    logic          w_addr_inc;
    logic          w_pending;
    logic          w_chk_ok;
    logic          w_drain_done;

    assign w_fall      = r_ss_q & ~spi_ss;
    assign w_hs        = wr_valid & wr_ready;
    assign w_data_byte = (r_state == S_DATA) & byte_en;
    assign w_op_bad    = (r_state == S_OPC) & byte_en & (byte_in != OP_WR) & (byte_in != OP_NOP);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_fall) w_state_nxt = S_OPC;
            S_OPC: begin
                if (spi_ss)       w_state_nxt = S_DONE;
                else if (byte_en) w_state_nxt = (byte_in == OP_WR) ? S_ADDR : S_SKIP;
            end
            S_ADDR: begin
                if (spi_ss)       w_state_nxt = S_DONE;
                else if (byte_en) w_state_nxt = S_DATA;
            end
            S_DATA:  if (spi_ss) w_state_nxt = S_DATA_END;
            S_SKIP:  if (spi_ss) w_state_nxt = S_DONE;
            S_CHK:   w_state_nxt = w_chk_ok ? S_DRAIN : S_DONE;
            S_DRAIN: if (w_drain_done) w_state_nxt = S_DONE;
            S_DONE:  if (!w_pending) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_ss_q    <= 1'b1;
            r_addr    <= '0;
            r_err_op  <= 1'b0;
            r_err_ovf <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ss_q    <= spi_ss;
            r_err_op  <= w_op_bad | (r_err_op & ~err_clr);
            r_err_ovf <= w_ovf | (r_err_ovf & ~err_clr);
            if ((r_state == S_ADDR) && byte_en) r_addr <= AW'(byte_in);
            else if (w_addr_inc)                 r_addr <= r_addr + 1'b1;
        end
    end

    assign frame_done = (r_state == S_DONE) & ~w_pending;
    assign err_op     = r_err_op;
    assign err_ovf    = r_err_ovf;

`ifdef SPI_CMD_CHK_EN
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [CHK_W-1:0] r_acc;
    logic [7:0]       r_last;
    logic             r_last_v;
    logic             r_buf_ovf;
    logic             r_err_chk;
    logic [CW-1:0]    w_buf_count;
    logic [7:0]       w_buf_dout;
    logic             w_buf_full;
    logic             w_buf_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_clear;
    logic             w_acc_byte;

    // The most recent data byte is held back: it becomes the checksum if the frame ends.
    assign w_buf_full   = (w_buf_count == CW'(BUF_DEPTH));
    assign w_buf_empty  = (w_buf_count == '0);
    assign w_push       = w_data_byte & r_last_v;
    assign w_pop        = (r_state == S_DRAIN) & w_hs;
    assign w_chk_ok     = r_last_v & ~r_buf_ovf & (r_acc == '0);
    assign w_clear      = ((r_state == S_IDLE) & w_fall) | ((r_state == S_CHK) & ~w_chk_ok);
    assign w_acc_byte   = byte_en & ((r_state == S_OPC) | (r_state == S_ADDR) | (r_state == S_DATA));
    assign w_ovf        = 1'b0;
    assign w_addr_inc   = w_pop;
    assign w_pending    = 1'b0;
    assign w_drain_done = w_buf_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc     <= '0;
            r_last    <= '0;
            r_last_v  <= 1'b0;
            r_buf_ovf <= 1'b0;
            r_err_chk <= 1'b0;
        end else begin
            r_err_chk <= ((r_state == S_CHK) & ~w_chk_ok) | (r_err_chk & ~err_clr);
            if ((r_state == S_IDLE) && w_fall) begin
                r_acc     <= '0;
                r_last_v  <= 1'b0;
                r_buf_ovf <= 1'b0;
            end else begin
                if (w_acc_byte) r_acc <= chk_step(r_acc, byte_in);
                if (w_data_byte) begin
                    r_last   <= byte_in;
                    r_last_v <= 1'b1;
                end
                if (w_push && w_buf_full) r_buf_ovf <= 1'b1;
            end
        end
    end

    spi_cmd_buf #(
        .DEPTH (BUF_DEPTH),
        .W     (8)
    ) u_buf (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_data  (r_last),
        .o_data  (w_buf_dout),
        .o_count (w_buf_count)
    );

    assign wr_valid = (r_state == S_DRAIN) & ~w_buf_empty;
    assign wr_addr  = r_addr;
    assign wr_data  = wr_valid ? w_buf_dout : 8'h00;
    assign err_chk  = r_err_chk;
`else
    logic          r_wr_valid;
    logic [AW-1:0] r_wr_addr;
    logic [7:0]    r_wr_data;

    // A byte that finds the holding register occupied is dropped, but its address slot is still consumed.
    assign w_ovf        = w_data_byte & r_wr_valid & ~wr_ready;
    assign w_addr_inc   = w_data_byte;
    assign w_pending    = r_wr_valid;
    assign w_chk_ok     = 1'b0;
    assign w_drain_done = 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else if (w_data_byte && !w_ovf) begin
            r_wr_valid <= 1'b1;
            r_wr_addr  <= r_addr;
            r_wr_data  <= byte_in;
        end else if (w_hs) begin
            r_wr_valid <= 1'b0;
        end
    end

    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign err_chk  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed self-checking bench for spi_cmd_ctrl; writes and frame_done pulses are logged by a monitor.
module tb_spi_cmd_ctrl;
    import spi_cmd_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       spi_ss = 1'b1;
    logic       byte_en = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       wr_valid;
    logic       wr_ready = 1'b1;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_done;
    logic       err_clr = 1'b0;
    logic       err_op;
    logic       err_ovf;
    logic       err_chk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] log_a[$];
    logic [7:0] log_d[$];
    int         fd_cnt = 0;
    logic [15:0] got;

    always #5 clk = ~clk;

    spi_cmd_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .spi_ss     (spi_ss),
        .byte_en    (byte_en),
        .byte_in    (byte_in),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .err_clr    (err_clr),
        .err_op     (err_op),
        .err_ovf    (err_ovf),
        .err_chk    (err_chk)
    );

    // Inputs only change at negedge, so values seen 2 ns later hold through the next posedge.
    always begin
        @(negedge clk);
        #2;
        if (wr_valid && wr_ready) begin
            log_a.push_back(wr_addr);
            log_d.push_back(wr_data);
        end
        if (frame_done) fd_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_en = 1'b1;
        byte_in = b;
        @(negedge clk);
        byte_en = 1'b0;
        cyc(2);
    endtask

    task automatic ss_start();
        @(negedge clk);
        spi_ss = 1'b0;
        cyc(2);
    endtask

    task automatic ss_end();
        @(negedge clk);
        spi_ss = 1'b1;
        cyc(8);
    endtask

    task automatic clr_log();
        log_a.delete();
        log_d.delete();
        fd_cnt = 0;
    endtask

    task automatic test_reset();
        cyc(2);
        #2;
        checks++;
        if ({wr_valid, wr_addr, wr_data} !== 17'h0) begin
            errors++; $display("FAIL reset_wr got v=%b a=%h d=%h want 0/00/00", wr_valid, wr_addr, wr_data);
        end
        checks++;
        if ({frame_done, err_op, err_ovf, err_chk} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {frame_done, err_op, err_ovf, err_chk});
        end
        checks++;
        if (dut.r_state !== S_IDLE) begin
            errors++; $display("FAIL reset_state got %0d want %0d", dut.r_state, S_IDLE);
        end
        @(negedge clk);
        rstn = 1'b1;
        cyc(3);
    endtask

    task automatic test_burst();
        clr_log();
        wr_ready = 1'b1;
        ss_start(); send(8'h02); send(8'h10); send(8'hAA); send(8'hBB); ss_end();
        checks++;
        if (log_a.size() !== 2) begin
            errors++; $display("FAIL burst_count got %0d want 2", log_a.size());
        end
        got = (log_a.size() > 0) ? {log_a[0], log_d[0]} : 16'hxxxx;
        checks++;
        if (got !== 16'h10AA) begin errors++; $display("FAIL burst_w0 got %h want 10AA", got); end
        got = (log_a.size() > 1) ? {log_a[1], log_d[1]} : 16'hxxxx;
        checks++;
        if (got !== 16'h11BB) begin errors++; $display("FAIL burst_w1 got %h want 11BB", got); end
        checks++;
        if ({fd_cnt[3:0], err_op, err_ovf} !== {4'd1, 2'b00}) begin
            errors++; $display("FAIL burst_done got fd=%0d op=%b ovf=%b want 1/0/0", fd_cnt, err_op, err_ovf);
        end
    endtask

    task automatic test_wrap();
        clr_log();
        ss_start(); send(8'h02); send(8'hFF); send(8'h01); send(8'h02); ss_end();
        got = (log_a.size() > 0) ? {log_a[0], log_d[0]} : 16'hxxxx;
        checks++;
        if (got !== 16'hFF01) begin errors++; $display("FAIL wrap_w0 got %h want FF01", got); end
        got = (log_a.size() > 1) ? {log_a[1], log_d[1]} : 16'hxxxx;
        checks++;
        if (got !== 16'h0002) begin errors++; $display("FAIL wrap_w1 got %h want 0002", got); end
        checks++;
        if ({log_a.size() == 2, err_ovf, err_op} !== 3'b100) begin
            errors++; $display("FAIL wrap_misc got n=%0d ovf=%b op=%b want 2/0/0", log_a.size(), err_ovf, err_op);
        end
    endtask

    task automatic test_backpressure();
        clr_log();
        wr_ready = 1'b0;
        ss_start(); send(8'h02); send(8'h20); send(8'h11);
        checks++;
        if ({wr_valid, wr_addr, wr_data} !== {1'b1, 8'h20, 8'h11}) begin
            errors++; $display("FAIL bp_hold1 got v=%b a=%h d=%h want 1/20/11", wr_valid, wr_addr, wr_data);
        end
        // Second data byte collides with the pending write; err_clr in the same cycle must lose.
        @(negedge clk);
        byte_en = 1'b1; byte_in = 8'h22; err_clr = 1'b1;
        @(negedge clk);
        byte_en = 1'b0; err_clr = 1'b0;
        #2;
        checks++;
        if (err_ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf got %b want 1", err_ovf); end
        @(negedge clk);
        spi_ss = 1'b1;
        cyc(5);
        checks++;
        if ({wr_valid, wr_addr, wr_data, fd_cnt[3:0]} !== {1'b1, 8'h20, 8'h11, 4'd0}) begin
            errors++; $display("FAIL bp_hold2 got v=%b a=%h d=%h fd=%0d want 1/20/11/0", wr_valid, wr_addr, wr_data, fd_cnt);
        end
        cyc(4);
        wr_ready = 1'b1;
        cyc(6);
        checks++;
        if (log_a.size() !== 1) begin errors++; $display("FAIL bp_count got %0d want 1", log_a.size()); end
        got = (log_a.size() > 0) ? {log_a[0], log_d[0]} : 16'hxxxx;
        checks++;
        if (got !== 16'h2011) begin errors++; $display("FAIL bp_w0 got %h want 2011", got); end
        checks++;
        if (fd_cnt !== 1) begin errors++; $display("FAIL bp_done got %0d want 1", fd_cnt); end
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        #2;
        checks++;
        if (err_ovf !== 1'b0) begin errors++; $display("FAIL bp_clr got %b want 0", err_ovf); end
    endtask

    task automatic test_opcodes();
        clr_log();
        ss_start(); send(8'h7E); send(8'h33); send(8'h44); ss_end();
        checks++;
        if ({log_a.size() == 0, err_op, fd_cnt[3:0]} !== {2'b11, 4'd1}) begin
            errors++; $display("FAIL op_bad got n=%0d op=%b fd=%0d want 0/1/1", log_a.size(), err_op, fd_cnt);
        end
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        #2;
        checks++;
        if (err_op !== 1'b0) begin errors++; $display("FAIL op_clr got %b want 0", err_op); end
        clr_log();
        ss_start(); send(8'h00); send(8'h55); ss_end();
        checks++;
        if ({log_a.size() == 0, err_op, fd_cnt[3:0]} !== {2'b10, 4'd1}) begin
            errors++; $display("FAIL op_nop got n=%0d op=%b fd=%0d want 0/0/1", log_a.size(), err_op, fd_cnt);
        end
    endtask

    task automatic test_reset_mid();
        clr_log();
        wr_ready = 1'b0;
        ss_start(); send(8'h02); send(8'h30); send(8'h77);
        checks++;
        if (wr_valid !== 1'b1) begin errors++; $display("FAIL rst_pre got %b want 1", wr_valid); end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if ({wr_valid, dut.r_state} !== {1'b0, S_IDLE}) begin
            errors++; $display("FAIL rst_now got v=%b st=%0d want 0/%0d", wr_valid, dut.r_state, S_IDLE);
        end
        spi_ss = 1'b1;
        cyc(2);
        rstn = 1'b1;
        wr_ready = 1'b1;
        cyc(2);
        clr_log();
        ss_start(); send(8'h02); send(8'h30); send(8'h5A); ss_end();
        got = (log_a.size() > 0) ? {log_a[0], log_d[0]} : 16'hxxxx;
        checks++;
        if ({log_a.size() == 1, got} !== {1'b1, 16'h305A}) begin
            errors++; $display("FAIL rst_after got n=%0d w=%h want 1/305A", log_a.size(), got);
        end
    endtask

    task automatic test_back_to_back();
        clr_log();
        ss_start(); send(8'h02); send(8'h50);
        // Last byte and ss rise in the same cycle.
        @(negedge clk);
        byte_en = 1'b1; byte_in = 8'hC3; spi_ss = 1'b1;
        @(negedge clk);
        byte_en = 1'b0;
        cyc(3);
        ss_start(); send(8'h02); send(8'h60); send(8'hD4); ss_end();
        got = (log_a.size() > 0) ? {log_a[0], log_d[0]} : 16'hxxxx;
        checks++;
        if (got !== 16'h50C3) begin errors++; $display("FAIL b2b_w0 got %h want 50C3", got); end
        got = (log_a.size() > 1) ? {log_a[1], log_d[1]} : 16'hxxxx;
        checks++;
        if (got !== 16'h60D4) begin errors++; $display("FAIL b2b_w1 got %h want 60D4", got); end
        checks++;
        if ({log_a.size() == 2, fd_cnt[3:0]} !== {1'b1, 4'd2}) begin
            errors++; $display("FAIL b2b_cnt got n=%0d fd=%0d want 2/2", log_a.size(), fd_cnt);
        end
    endtask

`ifdef SPI_CMD_CHK_EN
    task automatic test_chk();
        clr_log();
        wr_ready = 1'b1;
        ss_start(); send(8'h02); send(8'h40); send(8'h01); send(8'h43);
        checks++;
        if (log_a.size() !== 0) begin errors++; $display("FAIL chk_early got %0d want 0", log_a.size()); end
        ss_end();
        got = (log_a.size() > 0) ? {log_a[0], log_d[0]} : 16'hxxxx;
        checks++;
        if ({log_a.size() == 1, got, err_chk, fd_cnt[3:0]} !== {1'b1, 16'h4001, 1'b0, 4'd1}) begin
            errors++; $display("FAIL chk_good got n=%0d w=%h chk=%b fd=%0d want 1/4001/0/1", log_a.size(), got, err_chk, fd_cnt);
        end
        clr_log();
        ss_start(); send(8'h02); send(8'h40); send(8'h01); send(8'h00); ss_end();
        checks++;
        if ({log_a.size() == 0, err_chk, fd_cnt[3:0]} !== {2'b11, 4'd1}) begin
            errors++; $display("FAIL chk_bad got n=%0d chk=%b fd=%0d want 0/1/1", log_a.size(), err_chk, fd_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SPI_CMD_CHK_EN
        test_chk();
`else
        test_burst();
        test_wrap();
        test_backpressure();
        test_opcodes();
        test_reset_mid();
        test_back_to_back();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
